// File: rtl/cache_valid_ctrl_pkg.sv
// Shared cache geometry and encodings for the valid-table controller.
// The index width and depth are also used by the valid table and the tag RAM.
package cache_valid_ctrl_pkg;

    localparam int CACHE_IDX_W = 8;
    localparam int CACHE_DEPTH = 1 << CACHE_IDX_W;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_INIT  = 2'd0;
    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd1;
    localparam logic [STATE_W-1:0] ST_FLUSH = 2'd2;

    // Which requester owns the shared table port in an IDLE cycle.
    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_INV,
        GNT_FILL,
        GNT_LKUP
    } grant_e;

endpackage

// File: rtl/cache_valid_ctrl.sv
// Valid-table sequencer/arbiter: sweeps the unreset table to 0 after reset and
// on flush, otherwise grants the single index port to inv > fill > lookup.
module cache_valid_ctrl
    import cache_valid_ctrl_pkg::*;
#(
    parameter int IDX_W = CACHE_IDX_W,
    parameter int DEPTH = 1 << IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             flush_req_i,
    output logic             flush_ack_o,

    input  logic             inv_vld_i,
    input  logic [IDX_W-1:0] inv_idx_i,
    output logic             inv_rdy_o,

    input  logic             fill_vld_i,
    input  logic [IDX_W-1:0] fill_idx_i,
    output logic             fill_rdy_o,

    input  logic             lkup_vld_i,
    input  logic [IDX_W-1:0] lkup_idx_i,
    output logic             lkup_rdy_o,

    output logic             hit_vld_o,
    output logic             hit_valid_o,

    output logic [IDX_W-1:0] tbl_idx_o,
    output logic             tbl_wr_en_o,
    output logic             tbl_wr_valid_o,
    input  logic             tbl_rd_valid_i,

    output logic             busy_o
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               hit_vld_q, hit_vld_d;

    logic   idle;
    logic   cnt_last;
    grant_e grant;

    assign idle     = (state_q == ST_IDLE);
    assign cnt_last = (cnt_q == IDX_W'(DEPTH - 1));

    assign busy_o      = (state_q == ST_INIT) || (state_q == ST_FLUSH);
    assign flush_ack_o = (state_q == ST_FLUSH) && cnt_last;

    // A pending flush blocks every other requester for the cycle it is taken.
    assign inv_rdy_o  = idle && !flush_req_i;
    assign fill_rdy_o = idle && !flush_req_i && !inv_vld_i;
    assign lkup_rdy_o = idle && !flush_req_i && !inv_vld_i && !fill_vld_i;

    always_comb begin
        grant = GNT_NONE;
        if (inv_vld_i && inv_rdy_o) begin
            grant = GNT_INV;
        end else if (fill_vld_i && fill_rdy_o) begin
            grant = GNT_FILL;
        end else if (lkup_vld_i && lkup_rdy_o) begin
            grant = GNT_LKUP;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        state_d        = state_q;
        cnt_d          = cnt_q;
        hit_vld_d      = 1'b0;
        tbl_idx_o      = '0;
        tbl_wr_en_o    = 1'b0;
        tbl_wr_valid_o = 1'b0;

        case (state_q)
            ST_INIT, ST_FLUSH: begin
                tbl_wr_en_o = 1'b1;
                tbl_idx_o   = cnt_q;
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end

            ST_IDLE: begin
                cnt_d = '0;
                if (flush_req_i) begin
                    state_d = ST_FLUSH;
                end
                case (grant)
                    GNT_INV: begin
                        tbl_idx_o   = inv_idx_i;
                        tbl_wr_en_o = 1'b1;
                    end
                    GNT_FILL: begin
                        tbl_idx_o      = fill_idx_i;
                        tbl_wr_en_o    = 1'b1;
                        tbl_wr_valid_o = 1'b1;
                    end
                    GNT_LKUP: begin
                        tbl_idx_o = lkup_idx_i;
                        hit_vld_d = 1'b1;
                    end
                    default: ;
                endcase
            end

            // Unreachable encoding: recover by resweeping from index 0.
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            hit_vld_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep all flops sampling pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hit_vld_q <= hit_vld_d;
        end
    end

    // The table read data is already registered; only the strobe needs a flop.
    assign hit_vld_o   = hit_vld_q;
    assign hit_valid_o = tbl_rd_valid_i;

endmodule

// File: tb/tb_cache_valid_ctrl.sv
// Self-checking bench for cache_valid_ctrl: a behavioural valid table plus a
// reference model of expected table contents and arbitration outcomes.
module tb_cache_valid_ctrl;

    localparam int IDX_W = 8;
    localparam int DEPTH = 256;

    typedef enum int {W_NONE, W_FLUSH, W_INV, W_FILL, W_LKUP} winner_e;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush_req_i, flush_ack_o;
    logic             inv_vld_i, inv_rdy_o;
    logic [IDX_W-1:0] inv_idx_i;
    logic             fill_vld_i, fill_rdy_o;
    logic [IDX_W-1:0] fill_idx_i;
    logic             lkup_vld_i, lkup_rdy_o;
    logic [IDX_W-1:0] lkup_idx_i;
    logic             hit_vld_o, hit_valid_o;
    logic [IDX_W-1:0] tbl_idx_o;
    logic             tbl_wr_en_o, tbl_wr_valid_o;
    logic             tbl_rd_valid_i;
    logic             busy_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    bit ref_tbl [DEPTH];
    bit exp_hit_vld = 1'b0;
    bit exp_hit_val = 1'b0;

    // Behavioural valid table: no reset, starts all ones, registered read.
    logic [DEPTH-1:0] tbl_mem = '1;
    logic             tbl_rd_q = 1'b0;

    always @(posedge clk) begin
        if (tbl_wr_en_o) tbl_mem[tbl_idx_o] <= tbl_wr_valid_o;
        tbl_rd_q <= tbl_mem[tbl_idx_o];
    end
    assign tbl_rd_valid_i = tbl_rd_q;

    always #5 clk = ~clk;

    cache_valid_ctrl #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_req_i    (flush_req_i),
        .flush_ack_o    (flush_ack_o),
        .inv_vld_i      (inv_vld_i),
        .inv_idx_i      (inv_idx_i),
        .inv_rdy_o      (inv_rdy_o),
        .fill_vld_i     (fill_vld_i),
        .fill_idx_i     (fill_idx_i),
        .fill_rdy_o     (fill_rdy_o),
        .lkup_vld_i     (lkup_vld_i),
        .lkup_idx_i     (lkup_idx_i),
        .lkup_rdy_o     (lkup_rdy_o),
        .hit_vld_o      (hit_vld_o),
        .hit_valid_o    (hit_valid_o),
        .tbl_idx_o      (tbl_idx_o),
        .tbl_wr_en_o    (tbl_wr_en_o),
        .tbl_wr_valid_o (tbl_wr_valid_o),
        .tbl_rd_valid_i (tbl_rd_valid_i),
        .busy_o         (busy_o)
    );

    // Status vector layout while busy: {busy, ack, inv_rdy, fill_rdy, lkup_rdy, wr_en, wr_valid, idx, hit_vld}
    function automatic logic [15:0] sweep_vec();
        return {busy_o, flush_ack_o, inv_rdy_o, fill_rdy_o, lkup_rdy_o,
                tbl_wr_en_o, tbl_wr_valid_o, tbl_idx_o, hit_vld_o};
    endfunction

    // One cycle in IDLE: drive, compare against the model, advance to the next negedge.
    task automatic do_cycle(input string name, input logic fl,
                            input logic iv, input logic [IDX_W-1:0] ii,
                            input logic fv, input logic [IDX_W-1:0] fi,
                            input logic lv, input logic [IDX_W-1:0] li,
                            output winner_e won);
        logic e_inv, e_fill, e_lkup, e_wr_en, e_wr_val;
        logic [IDX_W-1:0] e_idx;
        logic [16:0] exp_v, act_v;
        flush_req_i = fl;
        inv_vld_i = iv;  inv_idx_i = ii;
        fill_vld_i = fv; fill_idx_i = fi;
        lkup_vld_i = lv; lkup_idx_i = li;
        #1;
        if (fl)      won = W_FLUSH;
        else if (iv) won = W_INV;
        else if (fv) won = W_FILL;
        else if (lv) won = W_LKUP;
        else         won = W_NONE;
        e_inv  = !fl;
        e_fill = !fl && !iv;
        e_lkup = !fl && !iv && !fv;
        e_wr_en = (won == W_INV) || (won == W_FILL);
        e_wr_val = (won == W_FILL);
        case (won)
            W_INV:   e_idx = ii;
            W_FILL:  e_idx = fi;
            W_LKUP:  e_idx = li;
            default: e_idx = '0;
        endcase
        exp_v = {2'b00, e_inv, e_fill, e_lkup, e_wr_en, e_wr_val, e_idx,
                 exp_hit_vld, exp_hit_val & exp_hit_vld};
        act_v = {busy_o, flush_ack_o, inv_rdy_o, fill_rdy_o, lkup_rdy_o, tbl_wr_en_o,
                 (e_wr_en ? tbl_wr_valid_o : 1'b0), tbl_idx_o,
                 hit_vld_o, (exp_hit_vld ? hit_valid_o : 1'b0)};
        n_checks++;
        if (act_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, act_v, exp_v);
        end
        if (won == W_INV)  ref_tbl[ii] = 1'b0;
        if (won == W_FILL) ref_tbl[fi] = 1'b1;
        exp_hit_vld = (won == W_LKUP);
        exp_hit_val = ref_tbl[li];
        @(negedge clk);
    endtask

    // n cycles of INIT/FLUSH sweep starting at index 0, with random requester noise.
    task automatic sweep(input string name, input logic hold, input logic ack_last, input int n);
        logic [15:0] exp_v, act_v;
        for (int k = 0; k < n; k++) begin
            flush_req_i = hold;
            inv_vld_i  = 1'($urandom); inv_idx_i  = 8'($urandom);
            fill_vld_i = 1'($urandom); fill_idx_i = 8'($urandom);
            lkup_vld_i = 1'($urandom); lkup_idx_i = 8'($urandom);
            #1;
            exp_v = {1'b1, (ack_last && k == DEPTH - 1), 3'b000, 1'b1, 1'b0, 8'(k), 1'b0};
            act_v = sweep_vec();
            n_checks++;
            if (act_v !== exp_v) begin
                n_errors++;
                $display("FAIL %s k=%0d: got %h expected %h", name, k, act_v, exp_v);
            end
            @(negedge clk);
        end
        inv_vld_i = 1'b0; fill_vld_i = 1'b0; lkup_vld_i = 1'b0;
        if (n == DEPTH) begin
            foreach (ref_tbl[i]) ref_tbl[i] = 1'b0;
            exp_hit_vld = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [15:0] act_v;
        rst_n = 1'b0;
        flush_req_i = 1'b0;
        inv_vld_i = 1'b0;  inv_idx_i = '0;
        fill_vld_i = 1'b0; fill_idx_i = '0;
        lkup_vld_i = 1'b0; lkup_idx_i = '0;
        repeat (3) @(negedge clk);
        #1;
        act_v = sweep_vec();
        n_checks++;
        if (act_v !== {1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 8'h00, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_values: got %h expected %h", act_v,
                     {1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 8'h00, 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_init_sweep();
        int bad;
        winner_e w;
        sweep("init_sweep", 1'b0, 1'b0, DEPTH);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (tbl_mem[i] !== 1'b0) bad++;
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL init_table_clear: got %0d nonzero entries expected 0", bad);
        end
        do_cycle("init_lkup_a", 0, 0, 0, 0, 0, 1, 8'h00, w);
        do_cycle("init_lkup_b", 0, 0, 0, 0, 0, 1, 8'hFF, w);
        do_cycle("init_lkup_c", 0, 0, 0, 0, 0, 1, 8'h80, w);
        do_cycle("init_idle",   0, 0, 0, 0, 0, 0, 8'h00, w);
    endtask

    task automatic test_fill_lookup();
        winner_e w;
        do_cycle("fill_12",   0, 0, 0, 1, 8'h12, 0, 8'h00, w);
        do_cycle("lkup_12",   0, 0, 0, 0, 8'h00, 1, 8'h12, w);
        do_cycle("lkup_13",   0, 0, 0, 0, 8'h00, 1, 8'h13, w);
        do_cycle("res_13",    0, 0, 0, 0, 8'h00, 0, 8'h00, w);
    endtask

    task automatic test_priority();
        winner_e w;
        do_cycle("prio_inv",  0, 1, 8'h12, 1, 8'h21, 1, 8'h21, w);
        do_cycle("prio_fill", 0, 0, 8'h00, 1, 8'h21, 1, 8'h21, w);
        do_cycle("prio_lkup", 0, 0, 8'h00, 0, 8'h00, 1, 8'h21, w);
        do_cycle("prio_res",  0, 0, 8'h00, 0, 8'h00, 1, 8'h12, w);
        do_cycle("prio_res2", 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, w);
    endtask

    task automatic test_back_to_back();
        winner_e w;
        do_cycle("b2b_fill5", 0, 0, 0, 1, 8'h05, 0, 8'h00, w);
        do_cycle("b2b_fill6", 0, 0, 0, 1, 8'h06, 0, 8'h00, w);
        for (int i = 5; i < 9; i++) do_cycle("b2b_lkup", 0, 0, 0, 0, 0, 1, 8'(i), w);
        do_cycle("b2b_tail", 0, 0, 0, 0, 0, 0, 8'h00, w);
    endtask

    task automatic test_flush();
        winner_e w;
        do_cycle("fl_fill40", 0, 0, 0, 1, 8'h40, 0, 8'h00, w);
        do_cycle("fl_fillff", 0, 0, 0, 1, 8'hFF, 0, 8'h00, w);
        do_cycle("fl_lkup40", 0, 0, 0, 0, 8'h00, 1, 8'h40, w);
        // In-flight lookup result is still delivered in the flush-entry cycle.
        do_cycle("fl_entry",  1, 1, 8'h40, 1, 8'h41, 1, 8'hFF, w);
        sweep("flush_sweep", 1'b1, 1'b1, DEPTH);
        do_cycle("fl_lkup40b", 0, 0, 0, 0, 8'h00, 1, 8'h40, w);
        do_cycle("fl_lkupffb", 0, 0, 0, 0, 8'h00, 1, 8'hFF, w);
        do_cycle("fl_tail",    0, 0, 0, 0, 8'h00, 0, 8'h00, w);
    endtask

    task automatic test_flush_during_init();
        winner_e w;
        @(negedge clk);
        rst_n = 1'b0;
        exp_hit_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sweep("init_w_flush", 1'b1, 1'b0, DEPTH);
        do_cycle("init_fl_entry", 1, 0, 0, 0, 0, 0, 8'h00, w);
        sweep("init_fl_sweep", 1'b1, 1'b1, DEPTH);
        do_cycle("init_fl_done", 0, 0, 0, 0, 0, 0, 8'h00, w);
    endtask

    task automatic test_reset_mid_sweep();
        logic [15:0] act_v;
        winner_e w;
        rst_n = 1'b0;
        exp_hit_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sweep("pre_rst_sweep", 1'b0, 1'b0, 100);
        #1;
        n_checks++;
        if (tbl_idx_o !== 8'd100) begin
            n_errors++;
            $display("FAIL mid_sweep_idx: got %0d expected 100", tbl_idx_o);
        end
        rst_n = 1'b0;
        #1;
        act_v = sweep_vec();
        n_checks++;
        if (act_v !== {1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 8'h00, 1'b0}) begin
            n_errors++;
            $display("FAIL async_reset: got %h expected %h", act_v,
                     {1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 8'h00, 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        sweep("post_rst_sweep", 1'b0, 1'b0, DEPTH);
        do_cycle("post_rst_idle", 0, 0, 0, 0, 0, 0, 8'h00, w);
    endtask

    task automatic test_random();
        winner_e w;
        logic fl, iv, fv, lv;
        logic [IDX_W-1:0] ii, fi, li;
        for (int n = 0; n < 600; n++) begin
            fl = ($urandom_range(0, 79) == 0);
            iv = ($urandom_range(0, 3) == 0);
            fv = ($urandom_range(0, 2) == 0);
            lv = ($urandom_range(0, 1) == 0);
            ii = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
            fi = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
            li = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
            do_cycle("rand", fl, iv, ii, fv, fi, lv, li, w);
            if (w == W_FLUSH) sweep("rand_flush", 1'b1, 1'b1, DEPTH);
        end
        do_cycle("rand_tail", 0, 0, 0, 0, 0, 0, 8'h00, w);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_init_sweep();
        test_fill_lookup();
        test_priority();
        test_back_to_back();
        test_flush();
        test_flush_during_init();
        test_reset_mid_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cache_valid_ctrl.md
# cache_valid_ctrl

Sequencer and arbiter for the cache's 256×1 valid table. The table has no reset and one shared index port, so this block does two jobs. First, it sweeps every entry to 0 after reset and on each fence.i flush request. Second, in normal operation it grants that single port once per cycle to invalidate, refill or lookup traffic. It sits between the cache pipeline/refill FSM and the valid table instance.

## Interface
- IDX_W, default 8: index width.
- DEPTH, default 256 (1<<IDX_W): number of table entries.
- clk  in  1  sole clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- flush_req_i  in  1  flush request; level, held until flush_ack_o.
- flush_ack_o  out  1  single-cycle completion pulse.
- inv_vld_i / inv_idx_i / inv_rdy_o  in / in / out  1 / IDX_W / 1  single-line invalidate (write 0).
- fill_vld_i / fill_idx_i / fill_rdy_o  in / in / out  1 / IDX_W / 1  refill (write 1).
- lkup_vld_i / lkup_idx_i / lkup_rdy_o  in / in / out  1 / IDX_W / 1  valid-bit lookup.
- hit_vld_o  out  1  lookup result strobe.
- hit_valid_o  out  1  lookup result (the valid bit).
- tbl_idx_o  out  IDX_W  table index.
- tbl_wr_en_o  out  1  table write enable.
- tbl_wr_valid_o  out  1  table write data.
- tbl_rd_valid_i  in  1  table registered read data.
- busy_o  out  1  high in INIT or FLUSH.

## Operation
- States:
  - INIT: reset state; sweep all entries.
  - IDLE: arbitrate requests.
  - FLUSH: sweep all entries.
- Sweep counter: IDX_W bits, reset to 0.
- In INIT/FLUSH, every cycle:
  - tbl_wr_en_o=1, tbl_wr_valid_o=0, tbl_idx_o=cnt; cnt increments.
  - When cnt==DEPTH-1: cnt wraps to 0 and the state goes to IDLE.
- flush_ack_o = (state==FLUSH && cnt==DEPTH-1), so the ack is asserted during the final sweep write.
- IDLE fixed priority, one grant per cycle: flush_req_i > inv > fill > lkup.
  - Flush: IDLE→FLUSH; nothing else is granted that cycle.
  - inv_rdy_o = IDLE && !flush_req_i.
  - fill_rdy_o = IDLE && !flush_req_i && !inv_vld_i.
  - lkup_rdy_o = IDLE && !flush_req_i && !inv_vld_i && !fill_vld_i.
  - All rdy signals are combinational; a transfer occurs when vld && rdy.
- Table drive in IDLE (combinational):
  - inv grant: idx=inv_idx_i, wr_en=1, wr_valid=0.
  - fill grant: idx=fill_idx_i, wr_en=1, wr_valid=1.
  - lkup grant: idx=lkup_idx_i, wr_en=0.
  - No grant: idx=0, wr_en=0.
- Lookup result:
  - hit_vld_o is a register, set the cycle after a lookup transfer and cleared otherwise.
  - hit_valid_o = tbl_rd_valid_i, passed through combinationally; qualified only by hit_vld_o.
- Same-index ordering: a write at edge N followed by a lookup granted in cycle N+1 returns the new value. No bypass is needed.
- flush_req_i during INIT waits; it is taken in the first IDLE cycle.
- Requester drops flush_req_i after the ack edge. The controller ignores the request while in FLUSH.
- Reset mid-sweep: asynchronous return to INIT with cnt=0; the sweep restarts from index 0.
- hit_vld_o is cleared by a flush entry only through the absence of a grant. An in-flight result issued the cycle before the flush is still delivered.

## Timing
- Reset values:
  - state=INIT, cnt=0, hit_vld_o=0, flush_ack_o=0, all rdy=0, busy_o=1.
  - tbl_wr_en_o=1, tbl_wr_valid_o=0, tbl_idx_o=0.
- After rst_n deasserts: cycles 0..255 are INIT writes to idx 0..255; the first IDLE cycle is 256.
- Flush: request seen in IDLE cycle F → sweep in cycles F+1..F+256 → ack in cycle F+256 → IDLE in cycle F+257.
- Lookup latency: 1 cycle (grant in cycle N, hit_vld_o/hit_valid_o in cycle N+1).
- Throughput: one table access per cycle; back-to-back lookups yield back-to-back results.

## Structure
- Shared defines file holds:
  - cache index width and depth, reused by the valid table, tag RAM and this block;
  - state encodings INIT=2'd0, IDLE=2'd1, FLUSH=2'd2.
- No sub-module. The counter, FSM and priority mux are small and stay in this module.

## Test plan
- Reset release → tbl_wr_en_o=1/tbl_wr_valid_o=0 with idx 0..255 over 256 cycles; busy_o drops at cycle 256; every table entry reads 0.
- Fill idx 0x12, then lookup 0x12 next cycle → hit_vld_o=1, hit_valid_o=1 one cycle after the lookup grant; lookup 0x13 → hit_valid_o=0.
- inv, fill and lkup all valid in the same IDLE cycle → only inv granted (inv_rdy_o=1, others 0); fill next, then lkup, on successive cycles.
- Fill 0x40 and 0xFF, then flush_req_i=1 → flush_ack_o pulses exactly 256 cycles after acceptance; lookups to 0x40 and 0xFF then return 0.
- flush_req_i asserted during INIT → FLUSH entered on the first IDLE cycle; ack 256 cycles later.
- rst_n pulsed low at sweep index 100 → outputs return to reset values asynchronously; the sweep restarts at idx 0 and runs a full 256 cycles.
